// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall-request polarity,
// exception type codes, controller state encoding and stall-vector constants.
package pipe_ctrl_pkg;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   localparam logic [31:0] EXC_INT  = 32'h0000_0001;
   localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
   localparam logic [31:0] EXC_INV  = 32'h0000_0009;
   localparam logic [31:0] EXC_OV   = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET = 32'h0000_000e;

   typedef enum logic [1:0] {
      PC_RUN   = 2'd0,
      PC_PEND  = 2'd1,
      PC_DRAIN = 2'd2
   } pc_state_t;

   // Stall vector bits: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
   localparam logic [5:0] STALL_MEM  = 6'b011111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_NONE = 6'b000000;

endpackage

// File: rtl/pipe_ctrl_exc_vector_sel.sv
// Exception vector selection: maps an exception type (and EPC for eret) to
// the handler address the pipeline is redirected to.
//   exc_type : exception type code
//   epc      : return address used for eret
//   vector   : redirect target
module exc_vector_sel
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
   input  logic [31:0] exc_type,
   input  logic [31:0] epc,
   output logic [31:0] vector
);

   always_comb begin
      case (exc_type)
         EXC_INT:                            vector = INT_VECTOR;
         EXC_ERET:                           vector = epc;
         EXC_SYS, EXC_INV, EXC_OV, EXC_TRAP: vector = EXC_VECTOR;
         default:                            vector = EXC_VECTOR;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit. Merges per-stage stall requests into the stage hold
// vector, sequences exception flushes (deferred while a data-bus access is
// outstanding), and keeps stall/flush counters plus a stall watchdog.
//   clk, rst            : clock, synchronous active-high reset
//   stallreq_from_*     : per-stage stall requests
//   excepttype_i        : exception type from mem stage (0 = none)
//   cp0_epc_i           : current EPC (bypassed)
//   stall               : stage hold vector
//   flush, new_pc       : one-cycle pipeline flush and redirect target
//   stall_cycles_o      : cycles with any stall
//   flush_count_o       : flush cycles issued
//   timeout_o           : sticky watchdog flag
//
// state    | meaning
// PC_RUN   | normal operation, exceptions accepted
// PC_PEND  | exception latched, waiting for the mem access to finish
// PC_DRAIN | cycle after a flush, mem-stage exception input is stale
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
   parameter int          WDOG_LIMIT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_if,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        stallreq_from_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles_o,
   output logic [15:0] flush_count_o,
   output logic        timeout_o
);

   localparam int             RUN_W   = $clog2(WDOG_LIMIT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WDOG_LIMIT);

   pc_state_t        state;
   logic [31:0]      pend_type;
   logic [31:0]      pend_epc;
   logic [31:0]      sel_type;
   logic [31:0]      sel_epc;
   logic [31:0]      vector;
   logic [RUN_W-1:0] run_cnt;

   // One vector selector, fed by the pending exception while deferred.
   assign sel_type = (state == PC_PEND) ? pend_type : excepttype_i;
   assign sel_epc  = (state == PC_PEND) ? pend_epc  : cp0_epc_i;

   exc_vector_sel #(
      .INT_VECTOR (INT_VECTOR),
      .EXC_VECTOR (EXC_VECTOR)
   ) u_vec (
      .exc_type (sel_type),
      .epc      (sel_epc),
      .vector   (vector)
   );

   always_comb begin
      flush  = 1'b0;
      stall  = STALL_NONE;
      new_pc = 32'h0;
      if (!rst) begin
         if (state == PC_PEND)
            flush = !stallreq_from_mem;
         else if (state == PC_RUN)
            flush = (excepttype_i != 32'h0) && !stallreq_from_mem;

         if (flush)
            new_pc = vector;
         else if (state == PC_PEND || stallreq_from_mem == Stop)
            stall = STALL_MEM;
         else if (stallreq_from_ex == Stop)
            stall = STALL_EX;
         else if (stallreq_from_id == Stop)
            stall = STALL_ID;
         else if (stallreq_from_if == Stop)
            stall = STALL_IF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= PC_RUN;
         pend_type      <= 32'h0;
         pend_epc       <= 32'h0;
         stall_cycles_o <= 32'h0;
         flush_count_o  <= 16'h0;
         run_cnt        <= '0;
         timeout_o      <= 1'b0;
      end else begin
         case (state)
            PC_RUN: begin
               if (excepttype_i != 32'h0) begin
                  if (stallreq_from_mem == Stop) begin
                     state     <= PC_PEND;
                     pend_type <= excepttype_i;
                     pend_epc  <= cp0_epc_i;
                  end else begin
                     state <= PC_DRAIN;
                  end
               end
            end
            PC_PEND:  if (stallreq_from_mem == NoStop) state <= PC_DRAIN;
            PC_DRAIN: state <= PC_RUN;
            default:  state <= PC_RUN;
         endcase

         if (flush)
            flush_count_o <= flush_count_o + 16'h1;

         if (stall != STALL_NONE) begin
            stall_cycles_o <= stall_cycles_o + 32'h1;
            if (run_cnt != RUN_MAX)
               run_cnt <= run_cnt + 1'b1;
            // This cycle brings the run count to the limit.
            if (run_cnt >= RUN_MAX - 1'b1)
               timeout_o <= 1'b1;
         end else begin
            run_cnt <= '0;
         end
      end
   end

endmodule
